branch_resolve_stage: RTL and testbench
=======================================

Name: branch_resolve_stage

Overview:
- Consumes the word-aligned branch offset from the shift-left-by-2 stage, together with PC+4 and the two register operands.
- Computes the branch target and resolves beq/bne.
- When a branch is taken, drives the PC-select redirect and the pipeline flush request.
- Squashes wrong-path instructions for a programmable shadow window and keeps saturating branch statistics.

Parameters:
- SHADOW_CYCLES, 1, cycles after REDIRECT during which incoming in_valid is squashed (legal range 0..15).
- CNT_W, 16, width of the statistics counters.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- stall  in  1  freezes all state, outputs and counters (rst and flush excepted).
- flush  in  1  external kill (exception path); aborts any redirect or shadow.
- in_valid  in  1  instruction present on the inputs this cycle.
- in_beq  in  1  instruction is beq.
- in_bne  in  1  instruction is bne.
- in_pc4  in  32  PC+4 of the instruction.
- in_offset  in  32  sign-extended immediate, already shifted left by 2.
- in_rs  in  32  rs operand.
- in_rt  in  32  rt operand.
- pc_src  out  1  select branch target for the next PC; high only in REDIRECT.
- pc_target  out  32  registered branch target.
- flush_req  out  1  flush IF/ID and ID/EX; high only in REDIRECT.
- busy  out  1  state is not IDLE.
- branch_count  out  CNT_W  branches evaluated (saturating).
- taken_count  out  CNT_W  branches taken (saturating).

Behaviour:
- Reset (async, immediate): state=IDLE, pc_src=0, flush_req=0, pc_target=0, busy=0, both counters=0, shadow counter=0.
- Priority per edge: rst > flush > stall > normal operation.
- States:
  - IDLE: an instruction is accepted when in_valid=1 and stall=0.
  - REDIRECT: exactly one non-stalled cycle; pc_src=1, flush_req=1.
  - SHADOW: lasts SHADOW_CYCLES non-stalled cycles; in_valid is ignored.
- Accept in IDLE; is_branch = in_beq | in_bne.
  - If both in_beq and in_bne are set, treat as beq.
  - cond = beq ? (in_rs == in_rt) : (in_rs != in_rt).
- On an accepted branch:
  - pc_target <= in_pc4 + in_offset (32-bit modular add, carry discarded, no overflow detection).
  - branch_count increments.
  - If cond: taken_count increments and next state = REDIRECT.
  - If not cond: pc_target is still updated; state stays IDLE.
- Accepted non-branch instruction: no state, target or counter change.
- Latency: branch accepted at edge T -> pc_src/flush_req high during cycle T+1 -> low at T+2.
- REDIRECT -> SHADOW if SHADOW_CYCLES>0, otherwise -> IDLE.
- SHADOW: the shadow counter is loaded with SHADOW_CYCLES on entry and decrements per non-stalled cycle; at 1 -> IDLE.
- in_valid during REDIRECT or SHADOW: squashed; no evaluation, no counting.
- Earliest next accept: one cycle after REDIRECT when SHADOW_CYCLES=0; otherwise one cycle after the last SHADOW cycle.
- stall=1: every register holds, including pc_src/flush_req, which stay high if stalled in REDIRECT; a redirect is never lost under stall.
- flush=1 (synchronous): state -> IDLE, shadow counter -> 0, pc_src/flush_req -> 0 next cycle. The input is not accepted that cycle; pc_target and counters hold.
- Counters saturate at 2^CNT_W-1; taken_count <= branch_count always.
- busy is purely decoded from the state register.

Test Plan:
- Reset mid-REDIRECT: assert rst asynchronously between edges -> pc_src, flush_req and busy drop immediately, counters read 0.
- Forward branch taken: beq, rs=rt=5, pc4=0x00400004, offset=0x00000010 -> cycle T+1: pc_target=0x00400014, pc_src=1, flush_req=1. Following in_valid squashed for 1 cycle; branch_count=1, taken_count=1.
- Negative offset and wrap:
  - bne, rs=1, rt=2, pc4=0x00400004, offset=0xFFFFFFF0 -> target 0x003FFFF4, taken.
  - pc4=0xFFFFFFFC, offset=0x8 -> target 0x00000004.
- Not taken and non-branch: beq rs=1, rt=2 -> pc_target updated, pc_src stays 0, branch_count+1, taken_count+0. in_valid with no branch flags -> nothing changes.
- Stall and flush:
  - Stall 3 cycles while in REDIRECT -> pc_src=1 held for all 3 cycles, then SHADOW.
  - flush during SHADOW with SHADOW_CYCLES=3 -> IDLE next cycle; a branch presented in that flush cycle is not counted.
- Saturation with CNT_W=4: 20 taken branches -> both counters stop at 15.

Source files
------------

// File: rtl/branch_resolve_stage.sv
// Branch resolution stage: forms the branch target, resolves beq/bne, raises the
// PC-select redirect and pipeline flush, squashes the wrong-path shadow and counts branches.
module branch_resolve_stage #(
    parameter int unsigned SHADOW_CYCLES = 1,
    parameter int unsigned CNT_W         = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             flush,
    input  logic             in_valid,
    input  logic             in_beq,
    input  logic             in_bne,
    input  logic [31:0]      in_pc4,
    input  logic [31:0]      in_offset,
    input  logic [31:0]      in_rs,
    input  logic [31:0]      in_rt,
    output logic             pc_src,
    output logic [31:0]      pc_target,
    output logic             flush_req,
    output logic             busy,
    output logic [CNT_W-1:0] branch_count,
    output logic [CNT_W-1:0] taken_count
);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] REDIRECT = 2'd1;
    localparam logic [1:0] SHADOW   = 2'd2;

    localparam logic [3:0]       SHADOW_LOAD = 4'(SHADOW_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    logic [1:0]  state;
    logic [3:0]  shadowCnt;
    logic        isBranch;
    logic        operandsEqual;
    logic        cond;
    logic        acceptBranch;
    logic [31:0] targetSum;

    // beq wins when both flags are set, so bne semantics apply only to a pure bne.
    always_comb begin
        isBranch      = in_beq | in_bne;
        operandsEqual = (in_rs == in_rt);
        cond          = in_beq ? operandsEqual : !operandsEqual;
        targetSum     = in_pc4 + in_offset;
        acceptBranch  = (state == IDLE) && in_valid && isBranch;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            shadowCnt <= '0;
        end else if (flush) begin
            state     <= IDLE;
            shadowCnt <= '0;
        end else if (!stall) begin
            case (state)
                IDLE: begin
                    if (acceptBranch && cond) begin
                        state <= REDIRECT;
                    end
                end
                REDIRECT: begin
                    if (SHADOW_LOAD != 4'd0) begin
                        state     <= SHADOW;
                        shadowCnt <= SHADOW_LOAD;
                    end else begin
                        state <= IDLE;
                    end
                end
                SHADOW: begin
                    if (shadowCnt <= 4'd1) begin
                        state     <= IDLE;
                        shadowCnt <= '0;
                    end else begin
                        shadowCnt <= shadowCnt - 4'd1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    shadowCnt <= '0;
                end
            endcase
        end
    end

    // Target and statistics only move on an evaluated branch; taken implies counted,
    // so taken_count can never overtake branch_count even at saturation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_target    <= '0;
            branch_count <= '0;
            taken_count  <= '0;
        end else if (!flush && !stall && acceptBranch) begin
            pc_target <= targetSum;
            if (branch_count != CNT_MAX) begin
                branch_count <= branch_count + CNT_ONE;
            end
            if (cond && (taken_count != CNT_MAX)) begin
                taken_count <= taken_count + CNT_ONE;
            end
        end
    end

    assign pc_src    = (state == REDIRECT);
    assign flush_req = (state == REDIRECT);
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_branch_resolve_stage.sv
// Scoreboard bench: two instances (short shadow/wide counters, long shadow/4-bit counters)
// share stimulus; a behavioural model predicts each cycle's outputs into per-instance queues.
module tb_branch_resolve_stage;

    logic        clk = 1'b0;
    logic        rst, stall, flush, in_valid, in_beq, in_bne;
    logic [31:0] in_pc4, in_offset, in_rs, in_rt;

    logic        srcA, frA, busyA;
    logic [31:0] tgtA;
    logic [15:0] bcA, tcA;
    logic        srcB, frB, busyB;
    logic [31:0] tgtB;
    logic [3:0]  bcB, tcB;

    branch_resolve_stage #(.SHADOW_CYCLES(1), .CNT_W(16)) dutA (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid),
        .in_beq(in_beq), .in_bne(in_bne), .in_pc4(in_pc4), .in_offset(in_offset),
        .in_rs(in_rs), .in_rt(in_rt), .pc_src(srcA), .pc_target(tgtA),
        .flush_req(frA), .busy(busyA), .branch_count(bcA), .taken_count(tcA)
    );

    branch_resolve_stage #(.SHADOW_CYCLES(3), .CNT_W(4)) dutB (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid),
        .in_beq(in_beq), .in_bne(in_bne), .in_pc4(in_pc4), .in_offset(in_offset),
        .in_rs(in_rs), .in_rt(in_rt), .pc_src(srcB), .pc_target(tgtB),
        .flush_req(frB), .busy(busyB), .branch_count(bcB), .taken_count(tcB)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          redirect;
        int          squashLeft;
        logic [31:0] target;
        int          bc;
        int          tc;
    } model_t;

    typedef struct {
        logic        src;
        logic        busy;
        logic [31:0] tgt;
        int          bc;
        int          tc;
    } exp_t;

    model_t mA, mB;
    exp_t   qA[$];
    exp_t   qB[$];
    int     nChecks = 0;
    int     nPass   = 0;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got === exp) nPass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    endtask

    // Model: a taken branch opens a one-cycle redirect, then a squash window of shadowN cycles.
    task automatic modelStep(input model_t mi, input int shadowN, input int cntMax, output model_t mo);
        bit taken;
        mo = mi;
        if (flush) begin
            mo.redirect   = 1'b0;
            mo.squashLeft = 0;
        end else if (!stall) begin
            if (mi.redirect) begin
                mo.redirect   = 1'b0;
                mo.squashLeft = shadowN;
            end else if (mi.squashLeft > 0) begin
                mo.squashLeft = mi.squashLeft - 1;
            end else if (in_valid && (in_beq || in_bne)) begin
                mo.target = in_pc4 + in_offset;
                if (mi.bc < cntMax) mo.bc = mi.bc + 1;
                taken = in_beq ? (in_rs == in_rt) : (in_rs != in_rt);
                if (taken) begin
                    if (mi.tc < cntMax) mo.tc = mi.tc + 1;
                    mo.redirect = 1'b1;
                end
            end
        end
    endtask

    function automatic exp_t expOf(input model_t m);
        exp_t e;
        e.src  = m.redirect;
        e.busy = m.redirect || (m.squashLeft > 0);
        e.tgt  = m.target;
        e.bc   = m.bc;
        e.tc   = m.tc;
        return e;
    endfunction

    task automatic compareOut();
        exp_t e;
        e = qA.pop_front();
        checkVal("A.pc_src",       32'(srcA),  32'(e.src));
        checkVal("A.flush_req",    32'(frA),   32'(e.src));
        checkVal("A.busy",         32'(busyA), 32'(e.busy));
        checkVal("A.pc_target",    tgtA,       e.tgt);
        checkVal("A.branch_count", 32'(bcA),   32'(e.bc));
        checkVal("A.taken_count",  32'(tcA),   32'(e.tc));
        e = qB.pop_front();
        checkVal("B.pc_src",       32'(srcB),  32'(e.src));
        checkVal("B.flush_req",    32'(frB),   32'(e.src));
        checkVal("B.busy",         32'(busyB), 32'(e.busy));
        checkVal("B.pc_target",    tgtB,       e.tgt);
        checkVal("B.branch_count", 32'(bcB),   32'(e.bc));
        checkVal("B.taken_count",  32'(tcB),   32'(e.tc));
    endtask

    task automatic cycle(input bit v, input bit beq, input bit bne, input logic [31:0] pc4,
                         input logic [31:0] off, input logic [31:0] rs, input logic [31:0] rt,
                         input bit st, input bit fl);
        model_t nA, nB;
        in_valid = v; in_beq = beq; in_bne = bne; in_pc4 = pc4;
        in_offset = off; in_rs = rs; in_rt = rt; stall = st; flush = fl;
        modelStep(mA, 1, 65535, nA);
        modelStep(mB, 3, 15, nB);
        mA = nA;
        mB = nB;
        qA.push_back(expOf(mA));
        qB.push_back(expOf(mB));
        @(posedge clk);
        #1;
        compareOut();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, '0, '0, '0, '0, 0, 0);
    endtask

    task automatic takenBranch();
        cycle(1, 1, 0, 32'h0000_2000, 32'h0000_0040, 32'd7, 32'd7, 0, 0);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkVal({tag, ".A.pc_src"},    32'(srcA),  32'd0);
        checkVal({tag, ".A.flush_req"}, 32'(frA),   32'd0);
        checkVal({tag, ".A.busy"},      32'(busyA), 32'd0);
        checkVal({tag, ".A.pc_target"}, tgtA,       32'd0);
        checkVal({tag, ".A.counts"},    {bcA, tcA}, 32'd0);
        checkVal({tag, ".B.pc_src"},    32'(srcB),  32'd0);
        checkVal({tag, ".B.busy"},      32'(busyB), 32'd0);
        checkVal({tag, ".B.counts"},    32'({bcB, tcB}), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; stall = 1'b0; flush = 1'b0; in_valid = 1'b0; in_beq = 1'b0; in_bne = 1'b0;
        in_pc4 = '0; in_offset = '0; in_rs = '0; in_rt = '0;
        mA = '{default: 0};
        mB = '{default: 0};
        #12;
        checkResetOutputs("reset");
        rst = 1'b0;

        // Forward taken beq, then a branch offered during the redirect/shadow is squashed.
        cycle(1, 1, 0, 32'h0040_0004, 32'h0000_0010, 32'd5, 32'd5, 0, 0);
        checkVal("fwd.target", tgtA, 32'h0040_0014);
        checkVal("fwd.pc_src", 32'(srcA), 32'd1);
        cycle(1, 1, 0, 32'h0040_0004, 32'h0000_0010, 32'd5, 32'd5, 0, 0);
        cycle(1, 1, 0, 32'h0040_0004, 32'h0000_0010, 32'd5, 32'd5, 0, 0);
        idle(3);
        checkVal("fwd.counts", {bcA, tcA}, 32'h0001_0001);

        // Negative offset and address wrap.
        cycle(1, 0, 1, 32'h0040_0004, 32'hFFFF_FFF0, 32'd1, 32'd2, 0, 0);
        checkVal("neg.target", tgtA, 32'h003F_FFF4);
        idle(4);
        cycle(1, 1, 0, 32'hFFFF_FFFC, 32'h0000_0008, 32'd0, 32'd0, 0, 0);
        checkVal("wrap.target", tgtA, 32'h0000_0004);
        idle(4);

        // Not taken, non-branch, and both flags set (beq semantics).
        cycle(1, 1, 0, 32'h0000_1000, 32'h0000_0020, 32'd1, 32'd2, 0, 0);
        checkVal("nt.target", tgtA, 32'h0000_1020);
        cycle(1, 0, 0, 32'h0000_3000, 32'h0000_0100, 32'd1, 32'd1, 0, 0);
        cycle(1, 1, 1, 32'h0000_4000, 32'h0000_0004, 32'd3, 32'd3, 0, 0);
        checkVal("both.pc_src", 32'(srcA), 32'd1);
        idle(4);

        // Stall held in REDIRECT.
        takenBranch();
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, '0, '0, '0, '0, 1, 0);
        checkVal("stall.pc_src", 32'(srcA), 32'd1);
        idle(4);

        // Flush during SHADOW: the branch offered in the flush cycle is not counted.
        takenBranch();
        idle(1);
        cycle(1, 1, 0, 32'h0000_5000, 32'h0000_0008, 32'd1, 32'd1, 0, 1);
        checkVal("flush.B.busy", 32'(busyB), 32'd0);
        cycle(1, 0, 1, 32'h0000_6000, 32'h0000_000C, 32'd1, 32'd9, 0, 0);
        idle(4);

        // Asynchronous reset mid-REDIRECT.
        takenBranch();
        #2 rst = 1'b1;
        #1 checkResetOutputs("asyncRst");
        @(posedge clk);
        #1 rst = 1'b0;
        mA = '{default: 0};
        mB = '{default: 0};

        // Saturation of the 4-bit counters.
        for (int i = 0; i < 20; i++) begin
            takenBranch();
            idle(4);
        end
        checkVal("sat.B.counts", 32'({bcB, tcB}), 32'h0000_00FF);
        checkVal("sat.A.counts", {bcA, tcA}, 32'h0014_0014);

        // Random mix with stalls and occasional flushes.
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom % 4) != 0, $urandom % 2 == 0, $urandom % 2 == 0, $urandom,
                  $urandom, 32'($urandom % 3), 32'($urandom % 3),
                  ($urandom % 6) == 0, ($urandom % 15) == 0);
        end

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
